// File: rtl/joystick_pkg.sv
// Joystick frame receiver shared types.
// Poll/parse states, UART register constants and sizing helper.
package joystick_pkg;

  typedef enum logic [1:0] {
    PEEK,
    PEEK_CHK,
    POP,
    POP_CAP
  } poll_state_t;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } parse_state_t;

  localparam int RVALID_BIT = 15;
  localparam logic [3:0] BE_PEEK = 4'b0010;
  localparam logic [3:0] BE_POP  = 4'b0001;

  function automatic int nbytes(input int ch_w);
    return (ch_w + 6) / 7;
  endfunction

endpackage

// File: rtl/joystick_frame_parser.sv
// Byte-stream framer: header, 7-bit payloads, optional XOR check.
// Emits one-cycle commit with channel id/value, plus error pulses.
module joystick_frame_parser
  import joystick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 8,
  parameter int CHECK_EN    = 1,
  parameter int TIMEOUT_CYC = 5000,
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            byte_vld,
  input  logic [7:0]      rx_byte,
  output logic            commit,
  output logic [IDW-1:0]  id,
  output logic [CH_W-1:0] value,
  output logic [1:0]      err_inc
);

  localparam int NB    = nbytes(CH_W);
  localparam int ACC_W = 7 * NB;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  parse_state_t     st;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [6:0]       chk;
  logic [1:0]       cnt;
  logic [TW-1:0]    tcnt;
  logic             hdr;
  logic             hdr_ok;

  assign hdr    = rx_byte[7];
  assign hdr_ok = rx_byte[6:0] < 7'(NUM_CH);
  assign acc_nx = (acc << 7) | ACC_W'(rx_byte[6:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= HUNT;
      acc     <= '0;
      chk     <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      commit  <= 1'b0;
      id      <= '0;
      value   <= '0;
      err_inc <= '0;
    end else begin
      commit  <= 1'b0;
      err_inc <= '0;
      if (byte_vld) begin
        tcnt <= '0;
        if (hdr) begin
          // resync and bad-id are separate error events
          err_inc <= 2'(st != HUNT) + 2'(!hdr_ok);
          acc     <= '0;
          chk     <= '0;
          cnt     <= '0;
          if (hdr_ok) begin
            st <= DATA;
            id <= rx_byte[IDW-1:0];
          end else begin
            st <= HUNT;
          end
        end else begin
          unique case (st)
            HUNT: err_inc <= 2'd1;
            DATA: begin
              acc <= acc_nx;
              chk <= chk ^ rx_byte[6:0];
              cnt <= cnt + 2'd1;
              if (cnt == 2'(NB - 1)) begin
                if (CHECK_EN != 0) begin
                  st <= CHECK;
                end else begin
                  st     <= HUNT;
                  commit <= 1'b1;
                  value  <= acc_nx[CH_W-1:0];
                end
              end
            end
            CHECK: begin
              st <= HUNT;
              if (rx_byte[6:0] == chk) begin
                commit <= 1'b1;
                value  <= acc[CH_W-1:0];
              end else begin
                err_inc <= 2'd1;
              end
            end
            default: st <= HUNT;
          endcase
        end
      end else if (st != HUNT) begin
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          tcnt    <= '0;
          st      <= HUNT;
          err_inc <= 2'd1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/joystick_frame_rx.sv
// UART-polling Avalon bridge with framed joystick channel capture.
// Channels commit atomically; CPU reads values, fresh flags, err_cnt.
module joystick_frame_rx
  import joystick_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 8,
  parameter int CHECK_EN    = 1,
  parameter int USE_IRQ     = 0,
  parameter int TIMEOUT_CYC = 5000,
  localparam int ADDR_W = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              m_address,
  output logic              m_cs,
  output logic [3:0]        m_byte_enable,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_write_data,
  input  logic [31:0]       m_read_data,
  input  logic              irq,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_cs,
  input  logic              s_read,
  output logic [15:0]       s_read_data
);

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  poll_state_t     ps;
  logic            run;
  logic            go;
  logic            byte_vld;
  logic [7:0]      rx_byte;
  logic            commit;
  logic [IDW-1:0]  cid;
  logic [CH_W-1:0] cval;
  logic [1:0]      err_inc;
  logic [CH_W-1:0] chan [NUM_CH];
  logic [NUM_CH-1:0] fresh;
  logic [7:0]      err_cnt;
  logic [8:0]      err_sum;
  logic            rd;
  logic            unused_rd;

  assign unused_rd = ^{m_read_data[31:16], m_read_data[14:8]};

  assign go = (USE_IRQ == 0) || irq;
  assign rd = s_cs && s_read;

  assign m_address    = 1'b0;
  assign m_cs         = 1'b1;
  assign m_write      = 1'b0;
  assign m_write_data = '0;

  // run holds strobes low until the first clock after reset
  assign m_read = run && ((ps == PEEK && go) || ps == POP);
  assign m_byte_enable = !m_read ? 4'b0 :
                         (ps == POP) ? BE_POP : BE_PEEK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps       <= PEEK;
      run      <= 1'b0;
      byte_vld <= 1'b0;
      rx_byte  <= '0;
    end else begin
      run      <= 1'b1;
      byte_vld <= 1'b0;
      unique case (ps)
        PEEK: if (run && go) ps <= PEEK_CHK;
        PEEK_CHK: begin
          ps <= m_read_data[RVALID_BIT] ? POP : PEEK;
        end
        POP: ps <= POP_CAP;
        POP_CAP: begin
          rx_byte  <= m_read_data[7:0];
          byte_vld <= 1'b1;
          ps       <= PEEK;
        end
        default: ps <= PEEK;
      endcase
    end
  end

  joystick_frame_parser #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .CHECK_EN   (CHECK_EN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_parser (
    .clk     (clk),
    .rst_n   (rst_n),
    .byte_vld(byte_vld),
    .rx_byte (rx_byte),
    .commit  (commit),
    .id      (cid),
    .value   (cval),
    .err_inc (err_inc)
  );

  assign err_sum = {1'b0, err_cnt} + 9'(err_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) chan[i] <= '0;
      fresh   <= '0;
      err_cnt <= '0;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      // a commit beats a same-cycle read clear
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit && cid == IDW'(i)) begin
          chan[i]  <= cval;
          fresh[i] <= 1'b1;
        end else if (rd && s_address == ADDR_W'(i)) begin
          fresh[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    s_read_data = '0;
    if (rd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (s_address == ADDR_W'(i)) s_read_data = 16'(chan[i]);
      end
      if (s_address == ADDR_W'(NUM_CH)) begin
        s_read_data = 16'(fresh);
      end
      if (s_address == ADDR_W'(NUM_CH + 1)) begin
        s_read_data = {8'h0, err_cnt};
      end
    end
  end

endmodule

// File: tb/tb_joystick_frame_rx.sv
// Bench for joystick_frame_rx: UART queue model, frame-level reference.
// Directed cases pin the model; random frames exercise the parser.
module tb_joystick_frame_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_address, m_cs, m_read, m_write;
  logic [3:0]  m_byte_enable;
  logic [31:0] m_write_data;
  logic [31:0] m_read_data;
  logic        irq;
  logic [2:0]  s_address;
  logic        s_cs, s_read;
  logic [15:0] s_read_data;

  logic        i_address, i_cs, i_read, i_write;
  logic [3:0]  i_be;
  logic [31:0] i_wd;
  logic [31:0] i_rdata;
  logic        irq2;
  logic [2:0]  i_saddr;
  logic        i_scs, i_sread;
  logic [15:0] i_srd;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_q[$];
  int cyc = 0;
  int last_pop = -100;

  int m_chan[4];
  logic [3:0] m_fresh;
  int m_err;

  joystick_frame_rx #(
    .NUM_CH(4), .CH_W(8), .CHECK_EN(1),
    .USE_IRQ(0), .TIMEOUT_CYC(5000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_cs(m_cs),
    .m_byte_enable(m_byte_enable), .m_read(m_read),
    .m_write(m_write), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .irq(irq),
    .s_address(s_address), .s_cs(s_cs),
    .s_read(s_read), .s_read_data(s_read_data)
  );

  joystick_frame_rx #(
    .NUM_CH(4), .CH_W(8), .CHECK_EN(1),
    .USE_IRQ(1), .TIMEOUT_CYC(5000)
  ) u_irq (
    .clk(clk), .rst_n(rst_n),
    .m_address(i_address), .m_cs(i_cs),
    .m_byte_enable(i_be), .m_read(i_read),
    .m_write(i_write), .m_write_data(i_wd),
    .m_read_data(i_rdata), .irq(irq2),
    .s_address(i_saddr), .s_cs(i_scs),
    .s_read(i_sread), .s_read_data(i_srd)
  );

  task automatic check(input string name, input int got,
                       input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, got, exp);
    end
  endtask

  // UART: data register answers one cycle after a read strobe
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_read_data <= '0;
    end else if (m_read && m_byte_enable == 4'b0001 &&
                 rx_q.size() > 0) begin
      m_read_data <= {16'($urandom), 1'b1, 7'($urandom),
                      rx_q.pop_front()};
    end else if (m_read) begin
      m_read_data <= {16'($urandom), rx_q.size() > 0,
                      15'($urandom)};
    end else begin
      m_read_data <= '0;
    end
  end

  // per-cycle master/slave invariants
  always @(negedge clk) begin
    if (!rst_n) begin
      check("strobe_in_reset", int'({m_read, i_read}), 0);
    end else begin
      check("m_const",
            int'({m_address, m_cs, m_write, m_write_data == 0}),
            int'(4'b0101));
      if (!irq2) check("irq_gate", int'(i_read), 0);
      if (!(s_cs && s_read))
        check("s_idle_zero", int'(s_read_data), 0);
      if (m_read) begin
        check("m_be_legal", int'(m_byte_enable == 4'b0010 ||
                                 m_byte_enable == 4'b0001), 1);
        if (m_byte_enable == 4'b0001) begin
          check("pop_nonempty", int'(rx_q.size() > 0), 1);
          check("pop_gap", int'(cyc - last_pop >= 4), 1);
          last_pop = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int b);
    rx_q.push_back(8'(b));
  endtask

  task automatic drain();
    int t = 0;
    while (rx_q.size() != 0 && t < 20000) begin
      step();
      t++;
    end
    if (rx_q.size() != 0) begin
      check("drain_timeout", rx_q.size(), 0);
      rx_q.delete();
    end
    repeat (10) step();
  endtask

  task automatic rd(input int a, output int d);
    step();
    s_cs = 1'b1;
    s_read = 1'b1;
    s_address = 3'(a);
    #1 d = int'(s_read_data);
    step();
    s_cs = 1'b0;
    s_read = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_chan[i] = 0;
    m_fresh = '0;
    m_err = 0;
  endtask

  task automatic add_err(input int n);
    m_err = (m_err + n > 255) ? 255 : m_err + n;
  endtask

  task automatic send_frame(input int id, input int p0,
                            input int p1, input int ck);
    push(8'h80 | id);
    push(p0);
    push(p1);
    push(ck);
  endtask

  function automatic int fval(input int p0, input int p1);
    return ((p0 << 7) | p1) & 8'hFF;
  endfunction

  task automatic compare_all(input string tag);
    int d;
    rd(4, d);
    check({tag, "_fresh"}, d, int'(m_fresh));
    rd(5, d);
    check({tag, "_err"}, d, m_err);
    for (int i = 0; i < 4; i++) begin
      rd(i, d);
      check($sformatf("%s_ch%0d", tag, i), d, m_chan[i]);
      m_fresh[i] = 1'b0;
    end
  endtask

  initial begin
    int d, old, nv, p0, p1, kind, id, n;
    bit need_hdr, saw_old, got_new, seen;
    irq = 1'b0;
    irq2 = 1'b0;
    i_rdata = '0;
    i_saddr = '0;
    i_scs = 1'b0;
    i_sread = 1'b0;
    s_cs = 1'b0;
    s_read = 1'b0;
    s_address = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all("reset");

    send_frame(2, 8'h01, 8'h25, 8'h24);
    drain();
    rd(4, d); check("t1_fresh", d, 4);
    rd(2, d); check("t1_ch2", d, 8'hA5);
    rd(4, d); check("t1_fresh_clr", d, 0);
    m_chan[2] = 8'hA5;

    send_frame(1, 8'h01, 8'h25, 8'h00);
    drain();
    rd(5, d); check("t2_err", d, 1);
    rd(1, d); check("t2_ch1", d, 0);
    m_err = 1;

    push(8'h80); push(8'h01);
    send_frame(3, 8'h00, 8'h7F, 8'h7F);
    drain();
    rd(4, d); check("t3_fresh", d, 8);
    rd(5, d); check("t3_err", d, 2);
    rd(3, d); check("t3_ch3", d, 8'h7F);
    rd(0, d); check("t3_ch0", d, 0);
    m_chan[3] = 8'h7F;
    m_err = 2;

    push(8'h85); push(8'h25);
    drain();
    rd(5, d); check("t4_err", d, 4);
    rd(4, d); check("t4_fresh", d, 0);
    m_err = 4;

    push(8'h82); push(8'h01);
    drain();
    repeat (4700) step();
    rd(5, d); check("t5_err_early", d, 4);
    repeat (400) step();
    rd(5, d); check("t5_err_timeout", d, 5);
    send_frame(2, 8'h00, 8'h33, 8'h33);
    drain();
    rd(2, d); check("t5_ch2", d, 8'h33);
    m_chan[2] = 8'h33;
    m_err = 5;
    compare_all("t5");

    push(8'h81); push(8'h05);
    drain();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    push(8'h25); push(8'h24);
    drain();
    rd(1, d); check("rst_ch1", d, 0);
    rd(5, d); check("rst_err", d, 2);
    m_err = 2;

    old = m_chan[2];
    nv = old ^ 8'h5A;
    p0 = nv >> 7;
    p1 = nv & 8'h7F;
    send_frame(2, p0, p1, p0 ^ p1);
    s_cs = 1'b1;
    s_read = 1'b1;
    s_address = 3'd2;
    saw_old = 1'b0;
    got_new = 1'b0;
    for (int t = 0; t < 400 && !got_new; t++) begin
      step();
      d = int'(s_read_data);
      if (d == nv) got_new = 1'b1;
      else if (d == old) saw_old = 1'b1;
      else check("same_cyc_val", d, old);
    end
    s_address = 3'd4;
    #1 check("same_cyc_fresh", int'(s_read_data), 4);
    check("same_cyc_new", int'(got_new), 1);
    check("same_cyc_old_seen", int'(saw_old), 1);
    s_cs = 1'b0;
    s_read = 1'b0;
    m_chan[2] = nv;
    m_fresh[2] = 1'b1;
    drain();
    compare_all("same_cyc");

    need_hdr = 1'b0;
    for (int it = 0; it < 80; it++) begin
      kind = (it == 79) ? 0 : $urandom_range(0, 4);
      if (need_hdr && kind == 4) kind = 0;
      if (need_hdr) begin
        add_err(1);
        need_hdr = 1'b0;
      end
      id = $urandom_range(0, 3);
      p0 = $urandom_range(0, 127);
      p1 = $urandom_range(0, 127);
      case (kind)
        0: begin
          send_frame(id, p0, p1, p0 ^ p1);
          m_chan[id] = fval(p0, p1);
          m_fresh[id] = 1'b1;
        end
        1: begin
          send_frame(id, p0, p1,
                     (p0 ^ p1) ^ $urandom_range(1, 127));
          add_err(1);
        end
        2: begin
          push(8'h80 | $urandom_range(4, 127));
          add_err(1);
        end
        3: begin
          push(8'h80 | id);
          n = $urandom_range(0, 2);
          for (int k = 0; k < n; k++) push($urandom_range(0, 127));
          need_hdr = 1'b1;
        end
        default: begin
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) push($urandom_range(0, 127));
          add_err(n);
        end
      endcase
      drain();
      if (it % 3 == 2 || it == 79)
        compare_all($sformatf("rnd%0d", it));
    end

    for (int k = 0; k < 300; k++) push(8'h25);
    add_err(300);
    drain();
    rd(5, d); check("sat_err", d, 255);
    push(8'h11);
    drain();
    rd(5, d); check("sat_hold", d, 255);
    compare_all("sat");

    irq2 = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (i_read) begin
        seen = 1'b1;
        check("irq_be", int'(i_be), int'(4'b0010));
      end
    end
    check("irq_read_seen", int'(seen), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
